wb_stage: RTL and testbench

- Write-back stage that sits directly upstream of the register file and drives its write port (WE, rW, W).
- Accepts completed instructions from the MEM stage over a valid/ready handshake.
- Selects ALU or load result, extracts and extends byte/halfword load data, and suppresses writes to r0.
- Holds up to two entries (main + skid) so MEM is never back-pressured combinationally; also exports a forwarding view of the pending write.

---
 rtl/wb_stage_if.sv | 31 +++
 rtl/wb_stage.sv | 136 +++++++++++++
 tb/tb_wb_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM -> WB completed-instruction handshake.
// Master is the MEM stage, slave is wb_stage.
interface wb_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic          in_regwrite;
  logic          in_memtoreg;
  logic [DW-1:0] in_alu;
  logic [DW-1:0] in_mem;
  logic [1:0]    in_lsize;
  logic          in_lsign;
  logic [1:0]    in_addr_lo;

  modport master (
    output in_valid, in_rd, in_regwrite,
    output in_memtoreg, in_alu, in_mem,
    output in_lsize, in_lsign, in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_regwrite,
    input  in_memtoreg, in_alu, in_mem,
    input  in_lsize, in_lsign, in_addr_lo,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: 2-entry (main + skid) buffer driving the regfile port.
// Optional WB_RETIRE_CNT_EN adds a 32-bit retire counter.
module wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_stage_if.slave     m,
  input  logic          wb_hold,
  output logic          WE,
  output logic [AW-1:0] rW,
  output logic [DW-1:0] W,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_rd,
`ifdef WB_RETIRE_CNT_EN
  output logic [DW-1:0] fwd_data,
  output logic [31:0]   retire_cnt
`else
  output logic [DW-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } st_t;

  st_t  st, st_n;
  ent_t main_q, skid_q, ent_in;
  logic acc, commit, main_v;
  logic ld_main, ld_skid, mv_skid;
  logic [15:0] h;
  logic [7:0]  b;
  logic [DW-1:0] d;

  assign main_v    = (st != EMPTY);
  assign m.in_ready = (st != TWO);
  assign acc       = m.in_valid & m.in_ready;
  assign commit    = main_v & ~wb_hold;

  // Load data is formatted at capture so the entry holds the final value.
  always_comb begin
    h = m.in_addr_lo[1] ? m.in_mem[31:16]
                        : m.in_mem[15:0];
    case (m.in_addr_lo)
      2'd0:    b = m.in_mem[7:0];
      2'd1:    b = m.in_mem[15:8];
      2'd2:    b = m.in_mem[23:16];
      default: b = m.in_mem[31:24];
    endcase
    d = m.in_mem;
    if (!m.in_memtoreg) begin
      d = m.in_alu;
    end else begin
      case (m.in_lsize)
        2'b01:
          d = {{(DW-16){m.in_lsign & h[15]}}, h};
        2'b10:
          d = {{(DW-8){m.in_lsign & b[7]}}, b};
        default:
          d = m.in_mem;
      endcase
    end
    ent_in.wr   = m.in_regwrite & (m.in_rd != '0);
    ent_in.rd   = m.in_rd;
    ent_in.data = d;
  end

  always_comb begin
    st_n    = st;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    unique case (st)
      EMPTY: begin
        if (acc) begin
          st_n    = ONE;
          ld_main = 1'b1;
        end
      end
      ONE: begin
        if (commit && acc) begin
          ld_main = 1'b1;
        end else if (commit) begin
          st_n = EMPTY;
        end else if (acc) begin
          st_n    = TWO;
          ld_skid = 1'b1;
        end
      end
      TWO: begin
        if (commit) begin
          st_n    = ONE;
          mv_skid = 1'b1;
        end
      end
      default: st_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      st <= st_n;
      if (ld_main)      main_q <= ent_in;
      else if (mv_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= ent_in;
    end
  end

  assign fwd_valid = main_v & main_q.wr;
  assign WE        = fwd_valid & ~wb_hold;
  assign rW        = main_q.rd;
  assign W         = main_q.data;
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.data;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_cnt <= '0;
    else if (commit) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Build with +define+WB_RETIRE_CNT_EN to cover the retire counter.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_hold;
  logic        WE;
  logic [4:0]  rW;
  logic [31:0] W;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  int          ecnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage_if bus ();

  wb_stage u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m         (bus),
    .wb_hold   (wb_hold),
    .WE        (WE),
    .rW        (rW),
    .W         (W),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
`ifdef WB_RETIRE_CNT_EN
    .fwd_data  (fwd_data),
    .retire_cnt(retire_cnt)
`else
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic [4:0]  rd,
    input logic        rw,
    input logic        mtr,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [1:0]  ls,
    input logic        sg,
    input logic [1:0]  lo
  );
    bus.in_valid    = 1'b1;
    bus.in_rd       = rd;
    bus.in_regwrite = rw;
    bus.in_memtoreg = mtr;
    bus.in_alu      = alu;
    bus.in_mem      = mem;
    bus.in_lsize    = ls;
    bus.in_lsign    = sg;
    bus.in_addr_lo  = lo;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(
    input string       tag,
    input logic [1:0]  ls,
    input logic        sg,
    input logic [1:0]  lo,
    input logic [31:0] exp
  );
    drive(5'd7, 1'b1, 1'b1, 32'hDEADBEEF,
          32'h80FF7F01, ls, sg, lo);
    step();
    idle();
    #1;
    chk({tag, "_we"}, 32'(WE), 32'd1);
    chk({tag, "_w"}, W, exp);
    step();
`ifdef WB_RETIRE_CNT_EN
    ecnt++;
`endif
  endtask

  initial begin
    wb_hold = 1'b0;
    idle();
    drive(5'd0, 1'b0, 1'b0, '0, '0, 2'd0, 1'b0, 2'd0);
    idle();
    #12;
    chk("rst_we", 32'(WE), 32'd0);
    chk("rst_w", W, 32'd0);
    chk("rst_rw", 32'(rW), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_fwd", 32'(fwd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset while two entries are held
    wb_hold = 1'b1;
    drive(5'd4, 1'b1, 1'b0, 32'hAAAA0004, '0,
          2'd0, 1'b0, 2'd0);
    step();
    drive(5'd5, 1'b1, 1'b0, 32'hAAAA0005, '0,
          2'd0, 1'b0, 2'd0);
    step();
    idle();
    #1;
    chk("two_rdy", 32'(bus.in_ready), 32'd0);
    chk("two_fwd", 32'(fwd_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_we", 32'(WE), 32'd0);
    chk("mrst_w", W, 32'd0);
    chk("mrst_rdy", 32'(bus.in_ready), 32'd1);
    chk("mrst_fwd", 32'(fwd_valid), 32'd0);
    @(negedge clk);
    wb_hold = 1'b0;
    rst_n = 1'b1;
    step();
    chk("mrst_post", 32'(WE), 32'd0);
    step();
    chk("mrst_post2", 32'(WE), 32'd0);

    // ALU write, visible for exactly one cycle
    drive(5'd2, 1'b1, 1'b0, 32'h88888888, '0,
          2'd0, 1'b0, 2'd0);
    step();
    idle();
    #1;
    chk("alu_we", 32'(WE), 32'd1);
    chk("alu_rw", 32'(rW), 32'd2);
    chk("alu_w", W, 32'h88888888);
    chk("alu_fd", fwd_data, 32'h88888888);
    step();
`ifdef WB_RETIRE_CNT_EN
    ecnt++;
`endif
    chk("alu_we_off", 32'(WE), 32'd0);

    load("lb3s", 2'b10, 1'b1, 2'd3, 32'hFFFFFF80);
    load("lbu1", 2'b10, 1'b0, 2'd1, 32'h0000007F);
    load("lh2s", 2'b01, 1'b1, 2'd2, 32'hFFFF80FF);
    load("lhu0", 2'b01, 1'b0, 2'd1, 32'h00007F01);
    load("lw", 2'b11, 1'b1, 2'd3, 32'h80FF7F01);

    // Write to r0 retires without WE
    drive(5'd0, 1'b1, 1'b0, 32'hFFFFFFFF, '0,
          2'd0, 1'b0, 2'd0);
    step();
    idle();
    #1;
    chk("r0_we", 32'(WE), 32'd0);
    chk("r0_fwd", 32'(fwd_valid), 32'd0);
    step();
`ifdef WB_RETIRE_CNT_EN
    ecnt++;
    chk("r0_cnt", retire_cnt, 32'(ecnt));
`endif
    chk("r0_we2", 32'(WE), 32'd0);

    // Back-pressure through the skid entry
    wb_hold = 1'b1;
    drive(5'd1, 1'b1, 1'b0, 32'h11, '0,
          2'd0, 1'b0, 2'd0);
    step();
    drive(5'd3, 1'b1, 1'b0, 32'h33, '0,
          2'd0, 1'b0, 2'd0);
    step();
    idle();
    #1;
    chk("bp_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp_we", 32'(WE), 32'd0);
    chk("bp_frd", 32'(fwd_rd), 32'd1);
    wb_hold = 1'b0;
    #1;
    chk("bp_a_we", 32'(WE), 32'd1);
    chk("bp_a_rw", 32'(rW), 32'd1);
    chk("bp_a_w", W, 32'h11);
    step();
    chk("bp_b_we", 32'(WE), 32'd1);
    chk("bp_b_rw", 32'(rW), 32'd3);
    chk("bp_b_w", W, 32'h33);
    chk("bp_rdy2", 32'(bus.in_ready), 32'd1);
    step();
    chk("bp_done", 32'(WE), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    ecnt += 2;
`endif

    // Streaming: one write per cycle, in order
    for (int i = 0; i < 8; i++) begin
      drive(5'(i + 8), 1'b1, 1'b0,
            32'h01010101 * (i + 1), '0,
            2'd0, 1'b0, 2'd0);
      step();
      chk("st_rdy", 32'(bus.in_ready), 32'd1);
      chk("st_we", 32'(WE), 32'd1);
      chk("st_rw", 32'(rW), 32'(i + 8));
      chk("st_w", W, 32'h01010101 * (i + 1));
    end
    idle();
    step();
    chk("st_end", 32'(WE), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    ecnt += 8;
    chk("st_cnt", retire_cnt, 32'(ecnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got %0d want 0", checks);
    $fatal(1);
  end

endmodule
